// File: rtl/mc_pkg.sv
// Shared encodings for the badmips multi-cycle control unit and its ALU.
package mc_pkg;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_NOR = 3'd3;
    localparam logic [2:0] ALU_ADD = 3'd4;
    localparam logic [2:0] ALU_SUB = 3'd5;
    localparam logic [2:0] ALU_SLT = 3'd6;
    localparam logic [2:0] ALU_SLL = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS    = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef logic [3:0] mc_state_t;

    localparam mc_state_t ST_IDLE     = 4'd0;
    localparam mc_state_t ST_FETCH    = 4'd1;
    localparam mc_state_t ST_DECODE   = 4'd2;
    localparam mc_state_t ST_EXEC_R   = 4'd3;
    localparam mc_state_t ST_EXEC_I   = 4'd4;
    localparam mc_state_t ST_MEM_ADDR = 4'd5;
    localparam mc_state_t ST_MEM_RD   = 4'd6;
    localparam mc_state_t ST_MEM_WB   = 4'd7;
    localparam mc_state_t ST_MEM_WR   = 4'd8;
    localparam mc_state_t ST_BRANCH   = 4'd9;
    localparam mc_state_t ST_JUMP     = 4'd10;
    localparam mc_state_t ST_WB_ALU   = 4'd11;
    localparam mc_state_t ST_HALT     = 4'd12;

    // Which ALU setup a state needs; states that leave the ALU idle use CLS_NONE.
    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_FETCH,
        CLS_DECODE,
        CLS_EXEC_R,
        CLS_EXEC_I,
        CLS_MEM_ADDR,
        CLS_BRANCH
    } alu_cls_e;

    function automatic logic ovf_checked(input logic [5:0] opcode, input logic [5:0] funct);
        return ((opcode == OP_RTYPE) && ((funct == F_ADD) || (funct == F_SUB))) ||
               (opcode == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU operation and operand-select decode for mc_control.
module mc_alu_decode
    import mc_pkg::*;
(
    input  alu_cls_e   i_cls,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_op,
    output logic [1:0] o_src_a,
    output logic [1:0] o_src_b,
    output logic       o_imm_zext,
    output logic       o_illegal
);

    always_comb begin
        o_alu_op   = ALU_AND;
        o_src_a    = SRCA_PC;
        o_src_b    = SRCB_RT;
        o_imm_zext = 1'b0;
        o_illegal  = 1'b0;
        case (i_cls)
            CLS_FETCH: begin
                o_alu_op = ALU_ADD;
                o_src_a  = SRCA_PC;
                o_src_b  = SRCB_FOUR;
            end
            CLS_DECODE: begin
                o_alu_op = ALU_ADD;
                o_src_a  = SRCA_PC;
                o_src_b  = SRCB_IMM_SH;
            end
            CLS_MEM_ADDR: begin
                o_alu_op = ALU_ADD;
                o_src_a  = SRCA_RS;
                o_src_b  = SRCB_IMM;
            end
            CLS_BRANCH: begin
                o_alu_op = ALU_SUB;
                o_src_a  = SRCA_RS;
                o_src_b  = SRCB_RT;
            end
            CLS_EXEC_R: begin
                o_src_a = SRCA_RS;
                o_src_b = SRCB_RT;
                case (i_funct)
                    F_ADD, F_ADDU: o_alu_op = ALU_ADD;
                    F_SUB, F_SUBU: o_alu_op = ALU_SUB;
                    F_AND:         o_alu_op = ALU_AND;
                    F_OR:          o_alu_op = ALU_OR;
                    F_XOR:         o_alu_op = ALU_XOR;
                    F_NOR:         o_alu_op = ALU_NOR;
                    F_SLT:         o_alu_op = ALU_SLT;
                    F_SLL: begin
                        o_alu_op = ALU_SLL;
                        o_src_a  = SRCA_SHAMT;
                    end
                    default: begin
                        o_src_a   = SRCA_PC;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            CLS_EXEC_I: begin
                o_src_a = SRCA_RS;
                o_src_b = SRCB_IMM;
                case (i_opcode)
                    OP_ADDI, OP_ADDIU: o_alu_op = ALU_ADD;
                    OP_SLTI:           o_alu_op = ALU_SLT;
                    OP_ANDI: begin
                        o_alu_op   = ALU_AND;
                        o_imm_zext = 1'b1;
                    end
                    OP_ORI: begin
                        o_alu_op   = ALU_OR;
                        o_imm_zext = 1'b1;
                    end
                    OP_XORI: begin
                        o_alu_op   = ALU_XOR;
                        o_imm_zext = 1'b1;
                    end
                    default: begin
                        o_src_a   = SRCA_PC;
                        o_src_b   = SRCB_RT;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the badmips datapath: sequences fetch/decode/execute/memory/writeback.
module mc_control
    import mc_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       ZF,
    input  logic       OF,
    input  logic       MEM_READY,
    output logic [2:0] ALU_OP,
    output logic [1:0] ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic       IMM_ZEXT,
    output logic       PC_WRITE,
    output logic       IR_WRITE,
    output logic       MEM_READ,
    output logic       MEM_WRITE,
    output logic       REG_WRITE,
    output logic [1:0] REG_DST,
    output logic [1:0] WB_SRC,
    output logic [1:0] PC_SRC,
    output logic       OVF,
    output logic       ILLEGAL
);

    mc_state_t r_state;
    mc_state_t w_next;
    logic      r_of;
    alu_cls_e  w_cls;
    logic      w_dec_illegal;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_of    <= 1'b0;
        end else begin
            r_state <= w_next;
            // Only signed add/sub/addi may suppress the following writeback.
            if ((r_state == ST_EXEC_R) || (r_state == ST_EXEC_I)) begin
                r_of <= OF & ovf_checked(OPCODE, FUNCT);
            end
        end
    end

    always_comb begin
        w_cls = CLS_NONE;
        case (r_state)
            ST_FETCH:    w_cls = CLS_FETCH;
            ST_DECODE:   w_cls = CLS_DECODE;
            ST_EXEC_R:   w_cls = CLS_EXEC_R;
            ST_EXEC_I:   w_cls = CLS_EXEC_I;
            ST_MEM_ADDR: w_cls = CLS_MEM_ADDR;
            ST_BRANCH:   w_cls = CLS_BRANCH;
            default:     w_cls = CLS_NONE;
        endcase
    end

    mc_alu_decode u_alu_decode (
        .i_cls      (w_cls),
        .i_opcode   (OPCODE),
        .i_funct    (FUNCT),
        .o_alu_op   (ALU_OP),
        .o_src_a    (ALU_SRC_A),
        .o_src_b    (ALU_SRC_B),
        .o_imm_zext (IMM_ZEXT),
        .o_illegal  (w_dec_illegal)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = ST_FETCH;
            ST_FETCH: if (MEM_READY) w_next = ST_DECODE;
            ST_DECODE: begin
                case (OPCODE)
                    OP_RTYPE:                    w_next = ST_EXEC_R;
                    OP_ADDI, OP_ADDIU, OP_SLTI,
                    OP_ANDI, OP_ORI, OP_XORI:    w_next = ST_EXEC_I;
                    OP_LW, OP_SW:                w_next = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:              w_next = ST_BRANCH;
                    OP_J, OP_JAL:                w_next = ST_JUMP;
                    default:                     w_next = ST_HALT;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: w_next = w_dec_illegal ? ST_HALT : ST_WB_ALU;
            ST_MEM_ADDR: w_next = (OPCODE == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (MEM_READY) w_next = ST_MEM_WB;
            ST_MEM_WR:   if (MEM_READY) w_next = ST_FETCH;
            ST_MEM_WB, ST_WB_ALU, ST_BRANCH, ST_JUMP: w_next = ST_FETCH;
            ST_HALT:     w_next = ST_HALT;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        PC_WRITE  = 1'b0;
        IR_WRITE  = 1'b0;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        REG_WRITE = 1'b0;
        REG_DST   = REGDST_RT;
        WB_SRC    = WB_ALUOUT;
        PC_SRC    = PCSRC_ALU;
        OVF       = 1'b0;
        ILLEGAL   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                MEM_READ = 1'b1;
                IR_WRITE = MEM_READY;
                PC_WRITE = MEM_READY;
                PC_SRC   = PCSRC_ALU;
            end
            ST_MEM_RD: MEM_READ  = 1'b1;
            ST_MEM_WR: MEM_WRITE = 1'b1;
            ST_MEM_WB: begin
                REG_WRITE = 1'b1;
                WB_SRC    = WB_MDR;
                REG_DST   = REGDST_RT;
            end
            ST_WB_ALU: begin
                REG_WRITE = ~r_of;
                OVF       = r_of;
                WB_SRC    = WB_ALUOUT;
                REG_DST   = (OPCODE == OP_RTYPE) ? REGDST_RD : REGDST_RT;
            end
            ST_BRANCH: begin
                PC_SRC   = PCSRC_ALUOUT;
                PC_WRITE = ((OPCODE == OP_BEQ) & ZF) | ((OPCODE == OP_BNE) & ~ZF);
            end
            ST_JUMP: begin
                PC_WRITE = 1'b1;
                PC_SRC   = PCSRC_JUMP;
                if (OPCODE == OP_JAL) begin
                    REG_WRITE = 1'b1;
                    REG_DST   = REGDST_RA;
                    WB_SRC    = WB_PC;
                end
            end
            ST_HALT: ILLEGAL = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Randomized self-checking bench for mc_control against an instruction-level output model.
module tb_mc_control;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] OPCODE, FUNCT;
    logic       ZF, OF, MEM_READY;
    logic [2:0] ALU_OP;
    logic [1:0] ALU_SRC_A, ALU_SRC_B;
    logic       IMM_ZEXT, PC_WRITE, IR_WRITE, MEM_READ, MEM_WRITE, REG_WRITE;
    logic [1:0] REG_DST, WB_SRC, PC_SRC;
    logic       OVF, ILLEGAL;

    mc_control dut (
        .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZF(ZF), .OF(OF),
        .MEM_READY(MEM_READY), .ALU_OP(ALU_OP), .ALU_SRC_A(ALU_SRC_A),
        .ALU_SRC_B(ALU_SRC_B), .IMM_ZEXT(IMM_ZEXT), .PC_WRITE(PC_WRITE),
        .IR_WRITE(IR_WRITE), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .REG_WRITE(REG_WRITE), .REG_DST(REG_DST), .WB_SRC(WB_SRC),
        .PC_SRC(PC_SRC), .OVF(OVF), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       zext;
        logic       pcw, irw, mr, mw, rw;
        logic [1:0] regdst, wbsrc, pcsrc;
        logic       ovf, ill;
    } out_t;

    out_t  act, exp_o;
    logic  exp_valid = 1'b0;
    string cyc_name = "none";
    int    n_checks = 0;
    int    n_err = 0;

    assign act = {ALU_OP, ALU_SRC_A, ALU_SRC_B, IMM_ZEXT, PC_WRITE, IR_WRITE, MEM_READ,
                  MEM_WRITE, REG_WRITE, REG_DST, WB_SRC, PC_SRC, OVF, ILLEGAL};

    always @(negedge CLK) begin
        if (exp_valid) begin
            n_checks++;
            if (act !== exp_o) begin
                n_err++;
                $display("FAIL %s @%0t: outputs got %06h want %06h (op=%02h fn=%02h)",
                         cyc_name, $time, act, exp_o, OPCODE, FUNCT);
            end
        end
    end

    task automatic check(input string nm, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // ---------------- instruction-level model ----------------
    function automatic out_t o_zero();
        out_t o = '0;
        return o;
    endfunction

    function automatic out_t o_fetch(input logic rdy);
        out_t o = '0;
        o.mr = 1'b1; o.alu_op = 3'd4; o.src_a = 2'd0; o.src_b = 2'd1;
        o.irw = rdy; o.pcw = rdy;
        return o;
    endfunction

    function automatic out_t o_decode();
        out_t o = '0;
        o.alu_op = 3'd4; o.src_a = 2'd0; o.src_b = 2'd3;
        return o;
    endfunction

    function automatic int r_alu(input logic [5:0] fn);
        case (fn)
            6'h20, 6'h21: return 4;
            6'h22, 6'h23: return 5;
            6'h24: return 0;
            6'h25: return 1;
            6'h26: return 2;
            6'h27: return 3;
            6'h2A: return 6;
            6'h00: return 7;
            default: return -1;
        endcase
    endfunction

    function automatic int i_alu(input logic [5:0] op);
        case (op)
            6'h08, 6'h09: return 4;
            6'h0A: return 6;
            6'h0C: return 0;
            6'h0D: return 1;
            6'h0E: return 2;
            default: return -1;
        endcase
    endfunction

    // 0 R, 1 I, 2 lw, 3 sw, 4 branch, 5 jump, 6 undecodable
    function automatic int kind(input logic [5:0] op);
        if (op == 6'h00) return 0;
        if (i_alu(op) >= 0) return 1;
        if (op == 6'h23) return 2;
        if (op == 6'h2B) return 3;
        if (op == 6'h04 || op == 6'h05) return 4;
        if (op == 6'h02 || op == 6'h03) return 5;
        return 6;
    endfunction

    function automatic int exp_len(input int k, input int fw, input int mw);
        int base[6] = '{4, 4, 5, 4, 3, 3};
        return base[k] + fw + ((k == 2 || k == 3) ? mw : 0);
    endfunction

    function automatic out_t o_exec(input logic [5:0] op, input logic [5:0] fn);
        out_t o = '0;
        int a;
        if (op == 6'h00) begin
            a = r_alu(fn);
            if (a < 0) return o;
            o.alu_op = 3'(a);
            o.src_a  = (fn == 6'h00) ? 2'd2 : 2'd1;
            o.src_b  = 2'd0;
        end else begin
            o.alu_op = 3'(i_alu(op));
            o.src_a  = 2'd1;
            o.src_b  = 2'd2;
            o.zext   = (op == 6'h0C || op == 6'h0D || op == 6'h0E);
        end
        return o;
    endfunction

    function automatic out_t o_wb(input logic [5:0] op, input logic [5:0] fn, input logic of);
        out_t o = '0;
        logic sup;
        sup = of && ((op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08);
        o.rw = !sup; o.ovf = sup;
        o.regdst = (op == 6'h00) ? 2'd1 : 2'd0;
        return o;
    endfunction

    function automatic out_t o_memaddr();
        out_t o = '0;
        o.alu_op = 3'd4; o.src_a = 2'd1; o.src_b = 2'd2;
        return o;
    endfunction

    function automatic out_t o_branch(input logic [5:0] op, input logic zf);
        out_t o = '0;
        o.alu_op = 3'd5; o.src_a = 2'd1; o.src_b = 2'd0; o.pcsrc = 2'd1;
        o.pcw = (op == 6'h04 && zf) || (op == 6'h05 && !zf);
        return o;
    endfunction

    function automatic out_t o_jump(input logic [5:0] op);
        out_t o = '0;
        o.pcw = 1'b1; o.pcsrc = 2'd2;
        if (op == 6'h03) begin
            o.rw = 1'b1; o.regdst = 2'd2; o.wbsrc = 2'd2;
        end
        return o;
    endfunction

    function automatic out_t o_halt();
        out_t o = '0;
        o.ill = 1'b1;
        return o;
    endfunction

    // ---------------- stimulus ----------------
    task automatic cyc(input string nm, input out_t e, input logic chk);
        cyc_name  = nm;
        exp_o     = e;
        exp_valid = chk;
        @(posedge CLK);
        #1;
    endtask

    task automatic noise();
        ZF        = 1'($urandom_range(1, 0));
        OF        = 1'($urandom_range(1, 0));
        MEM_READY = 1'($urandom_range(1, 0));
    endtask

    task automatic do_reset(input int n, input out_t entry, input logic entry_chk);
        noise();
        RST = 1'b1;
        cyc("rst_entry", entry, entry_chk);
        for (int i = 1; i < n; i++) begin
            noise();
            cyc("rst_idle", o_zero(), 1'b1);
        end
        RST = 1'b0;
        noise();
        cyc("idle", o_zero(), 1'b1);
    endtask

    task automatic halt_and_reset();
        for (int i = 0; i < 3; i++) begin
            noise();
            cyc("halt", o_halt(), 1'b1);
        end
        do_reset(1 + $urandom_range(1, 0), o_halt(), 1'b1);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw, input logic of, input logic zf,
                             output int len, output logic halted);
        out_t e;
        int   k;
        len = 0; halted = 1'b0; k = kind(op);
        OPCODE = op; FUNCT = fn;
        for (int i = 0; i < fw; i++) begin
            noise(); MEM_READY = 1'b0; cyc("fetch_wait", o_fetch(1'b0), 1'b1); len++;
        end
        noise(); MEM_READY = 1'b1; cyc("fetch", o_fetch(1'b1), 1'b1); len++;
        noise(); cyc("decode", o_decode(), 1'b1); len++;
        case (k)
            0, 1: begin
                noise(); OF = of; cyc("exec", o_exec(op, fn), 1'b1); len++;
                if (k == 0 && r_alu(fn) < 0) halted = 1'b1;
                else begin
                    noise(); cyc("wb_alu", o_wb(op, fn, of), 1'b1); len++;
                end
            end
            2, 3: begin
                noise(); cyc("mem_addr", o_memaddr(), 1'b1); len++;
                e = o_zero();
                if (k == 2) e.mr = 1'b1; else e.mw = 1'b1;
                for (int i = 0; i < mw; i++) begin
                    noise(); MEM_READY = 1'b0; cyc("mem_wait", e, 1'b1); len++;
                end
                noise(); MEM_READY = 1'b1; cyc("mem_done", e, 1'b1); len++;
                if (k == 2) begin
                    e = o_zero(); e.rw = 1'b1; e.wbsrc = 2'd1;
                    noise(); cyc("mem_wb", e, 1'b1); len++;
                end
            end
            4: begin
                noise(); ZF = zf; cyc("branch", o_branch(op, zf), 1'b1); len++;
            end
            5: begin
                noise(); cyc("jump", o_jump(op), 1'b1); len++;
            end
            default: halted = 1'b1;
        endcase
    endtask

    logic [5:0] legal_fn [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};
    logic [5:0] iops [6]      = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E};

    initial begin
        int   len;
        logic halted;
        out_t e;
        logic [5:0] op, fn;
        int   r;

        RST = 1'b1; MEM_READY = 1'b1; OPCODE = '0; FUNCT = '0; ZF = 1'b0; OF = 1'b0;

        // Model pins against hand-derived values.
        check("pin_sub_aluop", int'(o_exec(6'h00, 6'h22).alu_op), 5);
        check("pin_sll_aluop", int'(o_exec(6'h00, 6'h00).alu_op), 7);
        check("pin_sll_srca", int'(o_exec(6'h00, 6'h00).src_a), 2);
        check("pin_ori_aluop", int'(o_exec(6'h0D, 6'h00).alu_op), 1);
        check("pin_ori_zext", int'(o_exec(6'h0D, 6'h00).zext), 1);
        check("pin_ori_srcb", int'(o_exec(6'h0D, 6'h00).src_b), 2);
        check("pin_sub_ovf", int'(o_wb(6'h00, 6'h22, 1'b1).ovf), 1);
        check("pin_subu_rw", int'(o_wb(6'h00, 6'h23, 1'b1).rw), 1);
        check("pin_bne_zf1", int'(o_branch(6'h05, 1'b1).pcw), 0);
        check("pin_beq_zf1", int'(o_branch(6'h04, 1'b1).pcw), 1);
        check("pin_lw_len", exp_len(kind(6'h23), 0, 3), 8);

        MEM_READY = 1'b1;
        cyc("rst_entry", o_zero(), 1'b0);
        cyc("rst_idle", o_zero(), 1'b1);
        RST = 1'b0; MEM_READY = 1'b1;
        cyc("idle", o_zero(), 1'b1);

        run_instr(6'h00, 6'h22, 0, 0, 1'b1, 1'b0, len, halted); check("len_sub", len, 4);
        run_instr(6'h00, 6'h23, 0, 0, 1'b1, 1'b0, len, halted);
        run_instr(6'h00, 6'h20, 1, 0, 1'b1, 1'b0, len, halted); check("len_add_fw1", len, 5);
        run_instr(6'h00, 6'h21, 0, 0, 1'b1, 1'b0, len, halted);
        run_instr(6'h00, 6'h00, 0, 0, 1'b1, 1'b0, len, halted);
        run_instr(6'h0D, 6'h11, 0, 0, 1'b0, 1'b0, len, halted); check("len_ori", len, 4);
        run_instr(6'h08, 6'h00, 0, 0, 1'b1, 1'b0, len, halted);
        run_instr(6'h09, 6'h00, 0, 0, 1'b1, 1'b0, len, halted);
        run_instr(6'h23, 6'h00, 0, 3, 1'b0, 1'b0, len, halted); check("len_lw_w3", len, 8);
        run_instr(6'h23, 6'h00, 2, 0, 1'b0, 1'b0, len, halted);
        run_instr(6'h2B, 6'h00, 0, 0, 1'b0, 1'b0, len, halted); check("len_sw", len, 4);
        run_instr(6'h2B, 6'h00, 0, 2, 1'b0, 1'b0, len, halted);
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, 1'b1, len, halted); check("len_beq", len, 3);
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, 1'b0, len, halted);
        run_instr(6'h05, 6'h00, 0, 0, 1'b0, 1'b1, len, halted);
        run_instr(6'h05, 6'h00, 0, 0, 1'b0, 1'b0, len, halted);
        run_instr(6'h02, 6'h00, 0, 0, 1'b0, 1'b0, len, halted); check("len_j", len, 3);
        run_instr(6'h03, 6'h00, 0, 0, 1'b0, 1'b0, len, halted);

        // Reset while lw waits in MEM_RD.
        OPCODE = 6'h23; FUNCT = '0;
        noise(); MEM_READY = 1'b1; cyc("fetch", o_fetch(1'b1), 1'b1);
        noise(); cyc("decode", o_decode(), 1'b1);
        noise(); cyc("mem_addr", o_memaddr(), 1'b1);
        e = o_zero(); e.mr = 1'b1;
        noise(); MEM_READY = 1'b0; cyc("memrd_wait", e, 1'b1);
        RST = 1'b1; MEM_READY = 1'b0; cyc("memrd_rst", e, 1'b1);
        RST = 1'b0; MEM_READY = 1'b1; cyc("idle_after_rst", o_zero(), 1'b1);

        run_instr(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0, len, halted);
        check("halt_opcode", int'(halted), 1);
        halt_and_reset();
        run_instr(6'h00, 6'h3F, 0, 0, 1'b0, 1'b0, len, halted);
        halt_and_reset();

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(99, 0);
            fn = 6'($urandom);
            if (r < 30) begin
                op = 6'h00;
                if ($urandom_range(19, 0) != 0) fn = legal_fn[$urandom_range(9, 0)];
            end else if (r < 50) op = iops[$urandom_range(5, 0)];
            else if (r < 63) op = 6'h23;
            else if (r < 73) op = 6'h2B;
            else if (r < 86) op = ($urandom_range(1, 0) != 0) ? 6'h04 : 6'h05;
            else if (r < 97) op = ($urandom_range(1, 0) != 0) ? 6'h02 : 6'h03;
            else op = 6'($urandom);
            run_instr(op, fn, $urandom_range(2, 0), $urandom_range(3, 0),
                      1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), len, halted);
            if (halted) halt_and_reset();
        end

        exp_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
